// File: rtl/vmul_wb_collector.sv
// Writeback collector for the multiplier: buffers scalar results for the scalar regfile port
// and serialises vector results into LANES-wide beats, skipping beats with an empty mask.
module vmul_wb_collector #(
  parameter int SOFT_THREAD = 8,
  parameter int LANES       = 4,
  parameter int XLEN        = 32,
  parameter int REGIDX      = 5,
  parameter int REGEXT      = 2,
  parameter int DEPTH_WARP  = 2,
  localparam int NBEAT      = SOFT_THREAD / LANES,
  localparam int BW         = (NBEAT > 1) ? $clog2(NBEAT) : 1,
  localparam int IW         = REGIDX + REGEXT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        outx_valid_i,
  output logic                        outx_ready_o,
  input  logic [XLEN-1:0]             outx_wb_wxd_rd_i,
  input  logic                        outx_wxd_i,
  input  logic [IW-1:0]               outx_reg_idwx_i,
  input  logic [DEPTH_WARP-1:0]       outx_warp_id_i,
  input  logic                        outv_valid_i,
  output logic                        outv_ready_o,
  input  logic [SOFT_THREAD*XLEN-1:0] outv_wb_wxd_rd_i,
  input  logic [SOFT_THREAD-1:0]      outv_wvd_mask_i,
  input  logic                        outv_wvd_i,
  input  logic [IW-1:0]               outv_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]       outv_warp_id_i,
  output logic                        x_wr_valid_o,
  input  logic                        x_wr_ready_i,
  output logic [XLEN-1:0]             x_wr_data_o,
  output logic [IW-1:0]               x_wr_idx_o,
  output logic [DEPTH_WARP-1:0]       x_wr_wid_o,
  output logic                        v_wr_valid_o,
  input  logic                        v_wr_ready_i,
  output logic [LANES*XLEN-1:0]       v_wr_data_o,
  output logic [LANES-1:0]            v_wr_mask_o,
  output logic [BW-1:0]               v_wr_beat_o,
  output logic                        v_wr_last_o,
  output logic [IW-1:0]               v_wr_idx_o,
  output logic [DEPTH_WARP-1:0]       v_wr_wid_o,
  output logic                        busy_o
);

  localparam int BEAT_W = LANES * XLEN;

  typedef enum logic {IDLE, SEND} state_e;

  // Scalar one-entry buffer
  logic                  x_full_q, x_full_d;
  logic [XLEN-1:0]       x_data_q, x_data_d;
  logic [IW-1:0]         x_idx_q, x_idx_d;
  logic [DEPTH_WARP-1:0] x_wid_q, x_wid_d;
  logic                  x_accept;

  assign outx_ready_o = !x_full_q || x_wr_ready_i;
  assign x_accept     = outx_valid_i && outx_ready_o;
  assign x_wr_valid_o = x_full_q;
  assign x_wr_data_o  = x_data_q;
  assign x_wr_idx_o   = x_idx_q;
  assign x_wr_wid_o   = x_wid_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    x_full_d = x_full_q;
    x_data_d = x_data_q;
    x_idx_d  = x_idx_q;
    x_wid_d  = x_wid_q;
    if (x_full_q && x_wr_ready_i) x_full_d = 1'b0;
    if (x_accept && outx_wxd_i) begin
      x_full_d = 1'b1;
      x_data_d = outx_wb_wxd_rd_i;
      x_idx_d  = outx_reg_idwx_i;
      x_wid_d  = outx_warp_id_i;
    end
  end

  // Vector beat serialiser
  state_e                  state_q, state_d;
  logic [SOFT_THREAD*XLEN-1:0] v_data_q, v_data_d;
  logic [SOFT_THREAD-1:0]  v_mask_q, v_mask_d;
  logic [IW-1:0]           v_idx_q, v_idx_d;
  logic [DEPTH_WARP-1:0]   v_wid_q, v_wid_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [NBEAT-1:0]        held_nz, in_nz;
  logic [BW-1:0]           next_beat, first_beat;
  logic                    v_accept;

  always_comb begin
    for (int b = 0; b < NBEAT; b++) begin
      held_nz[b] = |v_mask_q[b*LANES +: LANES];
      in_nz[b]   = |outv_wvd_mask_i[b*LANES +: LANES];
    end
  end

  // Descending scans so the lowest qualifying beat wins.
  always_comb begin
    next_beat   = beat_q;
    v_wr_last_o = 1'b1;
    first_beat  = '0;
    for (int b = NBEAT - 1; b >= 0; b--) begin
      if (held_nz[b] && (b > int'(beat_q))) begin
        next_beat   = BW'(b);
        v_wr_last_o = 1'b0;
      end
      if (in_nz[b]) first_beat = BW'(b);
    end
  end

  always_comb begin
    v_wr_data_o = '0;
    v_wr_mask_o = '0;
    for (int b = 0; b < NBEAT; b++) begin
      if (beat_q == BW'(b)) begin
        v_wr_data_o = v_data_q[b*BEAT_W +: BEAT_W];
        v_wr_mask_o = v_mask_q[b*LANES +: LANES];
      end
    end
  end

  assign v_wr_valid_o = (state_q == SEND);
  assign outv_ready_o = (state_q == IDLE) || (v_wr_valid_o && v_wr_ready_i && v_wr_last_o);
  assign v_accept     = outv_valid_i && outv_ready_o;
  assign v_wr_beat_o  = beat_q;
  assign v_wr_idx_o   = v_idx_q;
  assign v_wr_wid_o   = v_wid_q;
  assign busy_o       = x_full_q || v_wr_valid_o;

  always_comb begin
    state_d  = state_q;
    v_data_d = v_data_q;
    v_mask_d = v_mask_q;
    v_idx_d  = v_idx_q;
    v_wid_d  = v_wid_q;
    beat_d   = beat_q;
    if (v_wr_valid_o && v_wr_ready_i) begin
      if (v_wr_last_o) state_d = IDLE;
      else             beat_d  = next_beat;
    end
    // A same-cycle accept overrides the return to IDLE after the last beat.
    if (v_accept) begin
      v_data_d = outv_wb_wxd_rd_i;
      v_mask_d = outv_wvd_mask_i;
      v_idx_d  = outv_reg_idxw_i;
      v_wid_d  = outv_warp_id_i;
      beat_d   = first_beat;
      state_d  = (outv_wvd_i && |in_nz) ? SEND : IDLE;
    end
  end

  // NOTE: payload registers are plain flops, not a memory array, so clearing them on reset is cheap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      x_full_q <= 1'b0;
      x_data_q <= '0;
      x_idx_q  <= '0;
      x_wid_q  <= '0;
      state_q  <= IDLE;
      v_data_q <= '0;
      v_mask_q <= '0;
      v_idx_q  <= '0;
      v_wid_q  <= '0;
      beat_q   <= '0;
    end else begin
      x_full_q <= x_full_d;
      x_data_q <= x_data_d;
      x_idx_q  <= x_idx_d;
      x_wid_q  <= x_wid_d;
      state_q  <= state_d;
      v_data_q <= v_data_d;
      v_mask_q <= v_mask_d;
      v_idx_q  <= v_idx_d;
      v_wid_q  <= v_wid_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_vmul_wb_collector.sv
// Directed bench for vmul_wb_collector with SOFT_THREAD=8, LANES=4, XLEN=32.
module tb_vmul_wb_collector;

  localparam int ST = 8;
  localparam int LN = 4;
  localparam int XL = 32;
  localparam int IW = 7;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic outx_valid_i, outx_ready_o, outx_wxd_i;
  logic [XL-1:0] outx_wb_wxd_rd_i;
  logic [IW-1:0] outx_reg_idwx_i;
  logic [WW-1:0] outx_warp_id_i;
  logic outv_valid_i, outv_ready_o, outv_wvd_i;
  logic [ST*XL-1:0] outv_wb_wxd_rd_i;
  logic [ST-1:0] outv_wvd_mask_i;
  logic [IW-1:0] outv_reg_idxw_i;
  logic [WW-1:0] outv_warp_id_i;
  logic x_wr_valid_o, x_wr_ready_i;
  logic [XL-1:0] x_wr_data_o;
  logic [IW-1:0] x_wr_idx_o;
  logic [WW-1:0] x_wr_wid_o;
  logic v_wr_valid_o, v_wr_ready_i, v_wr_last_o, busy_o;
  logic [LN*XL-1:0] v_wr_data_o;
  logic [LN-1:0] v_wr_mask_o;
  logic [0:0] v_wr_beat_o;
  logic [IW-1:0] v_wr_idx_o;
  logic [WW-1:0] v_wr_wid_o;

  int checks = 0;
  int errors = 0;

  localparam logic [ST*XL-1:0] VEC_A = {32'h107, 32'h106, 32'h105, 32'h104,
                                        32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [ST*XL-1:0] VEC_B = {32'h207, 32'h206, 32'h205, 32'h204,
                                        32'h203, 32'h202, 32'h201, 32'h200};

  vmul_wb_collector #(.SOFT_THREAD(ST), .LANES(LN), .XLEN(XL), .REGIDX(5), .REGEXT(2),
                      .DEPTH_WARP(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .outx_valid_i(outx_valid_i), .outx_ready_o(outx_ready_o),
    .outx_wb_wxd_rd_i(outx_wb_wxd_rd_i), .outx_wxd_i(outx_wxd_i),
    .outx_reg_idwx_i(outx_reg_idwx_i), .outx_warp_id_i(outx_warp_id_i),
    .outv_valid_i(outv_valid_i), .outv_ready_o(outv_ready_o),
    .outv_wb_wxd_rd_i(outv_wb_wxd_rd_i), .outv_wvd_mask_i(outv_wvd_mask_i),
    .outv_wvd_i(outv_wvd_i), .outv_reg_idxw_i(outv_reg_idxw_i),
    .outv_warp_id_i(outv_warp_id_i),
    .x_wr_valid_o(x_wr_valid_o), .x_wr_ready_i(x_wr_ready_i),
    .x_wr_data_o(x_wr_data_o), .x_wr_idx_o(x_wr_idx_o), .x_wr_wid_o(x_wr_wid_o),
    .v_wr_valid_o(v_wr_valid_o), .v_wr_ready_i(v_wr_ready_i),
    .v_wr_data_o(v_wr_data_o), .v_wr_mask_o(v_wr_mask_o), .v_wr_beat_o(v_wr_beat_o),
    .v_wr_last_o(v_wr_last_o), .v_wr_idx_o(v_wr_idx_o), .v_wr_wid_o(v_wr_wid_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    outx_valid_i = 0; outx_wxd_i = 0; outx_wb_wxd_rd_i = '0; outx_reg_idwx_i = '0; outx_warp_id_i = '0;
    outv_valid_i = 0; outv_wvd_i = 0; outv_wb_wxd_rd_i = '0; outv_wvd_mask_i = '0;
    outv_reg_idxw_i = '0; outv_warp_id_i = '0;
    x_wr_ready_i = 0; v_wr_ready_i = 0;
    step(); step();
    checks++; if (x_wr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_x_valid got %0b want 0", x_wr_valid_o); end
    checks++; if (v_wr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_v_valid got %0b want 0", v_wr_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy_o); end
    checks++; if (outx_ready_o !== 1'b1) begin errors++; $display("FAIL rst_outx_ready got %0b want 1", outx_ready_o); end
    checks++; if (outv_ready_o !== 1'b1) begin errors++; $display("FAIL rst_outv_ready got %0b want 1", outv_ready_o); end
    checks++; if (x_wr_data_o !== 32'h0 || v_wr_beat_o !== 1'b0) begin
      errors++; $display("FAIL rst_regs got data=%0h beat=%0b want 0/0", x_wr_data_o, v_wr_beat_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_scalar();
    x_wr_ready_i = 1;
    outx_valid_i = 1; outx_wxd_i = 1; outx_wb_wxd_rd_i = 32'h1234; outx_reg_idwx_i = 7'd5; outx_warp_id_i = 2'd2;
    checks++; if (outx_ready_o !== 1'b1) begin errors++; $display("FAIL sc_ready got %0b want 1", outx_ready_o); end
    step();
    checks++; if (x_wr_valid_o !== 1'b1 || x_wr_data_o !== 32'h1234 || x_wr_idx_o !== 7'd5 || x_wr_wid_o !== 2'd2) begin
      errors++; $display("FAIL sc_first got v=%0b d=%0h i=%0d w=%0d want 1/1234/5/2",
                         x_wr_valid_o, x_wr_data_o, x_wr_idx_o, x_wr_wid_o); end
    outx_wb_wxd_rd_i = 32'h1111;
    step();
    checks++; if (x_wr_valid_o !== 1'b1 || x_wr_data_o !== 32'h1111) begin
      errors++; $display("FAIL sc_b2b1 got v=%0b d=%0h want 1/1111", x_wr_valid_o, x_wr_data_o); end
    outx_wb_wxd_rd_i = 32'h2222;
    step();
    checks++; if (x_wr_valid_o !== 1'b1 || x_wr_data_o !== 32'h2222) begin
      errors++; $display("FAIL sc_b2b2 got v=%0b d=%0h want 1/2222", x_wr_valid_o, x_wr_data_o); end
    outx_wxd_i = 0; outx_wb_wxd_rd_i = 32'h3333;
    step();
    checks++; if (x_wr_valid_o !== 1'b0) begin errors++; $display("FAIL sc_discard got %0b want 0", x_wr_valid_o); end
    outx_valid_i = 0;
    step();
  endtask

  task automatic test_scalar_stall();
    x_wr_ready_i = 0;
    outx_valid_i = 1; outx_wxd_i = 1; outx_wb_wxd_rd_i = 32'hAAAA; outx_reg_idwx_i = 7'd9; outx_warp_id_i = 2'd1;
    step();
    outx_wb_wxd_rd_i = 32'hBBBB; outx_reg_idwx_i = 7'd10; outx_warp_id_i = 2'd3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (outx_ready_o !== 1'b0) begin errors++; $display("FAIL st_ready%0d got %0b want 0", i, outx_ready_o); end
      checks++; if (x_wr_valid_o !== 1'b1 || x_wr_data_o !== 32'hAAAA || x_wr_idx_o !== 7'd9) begin
        errors++; $display("FAIL st_hold%0d got v=%0b d=%0h i=%0d want 1/aaaa/9", i, x_wr_valid_o, x_wr_data_o, x_wr_idx_o); end
      step();
    end
    x_wr_ready_i = 1;
    #1;
    checks++; if (outx_ready_o !== 1'b1) begin errors++; $display("FAIL st_release got %0b want 1", outx_ready_o); end
    step();
    outx_valid_i = 0;
    checks++; if (x_wr_valid_o !== 1'b1 || x_wr_data_o !== 32'hBBBB || x_wr_wid_o !== 2'd3) begin
      errors++; $display("FAIL st_second got v=%0b d=%0h w=%0d want 1/bbbb/3", x_wr_valid_o, x_wr_data_o, x_wr_wid_o); end
    step();
    checks++; if (x_wr_valid_o !== 1'b0) begin errors++; $display("FAIL st_empty got %0b want 0", x_wr_valid_o); end
  endtask

  task automatic test_vector_full();
    v_wr_ready_i = 1;
    outv_valid_i = 1; outv_wvd_i = 1; outv_wb_wxd_rd_i = VEC_A; outv_wvd_mask_i = 8'hFF;
    outv_reg_idxw_i = 7'd7; outv_warp_id_i = 2'd1;
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b1 || v_wr_beat_o !== 1'b0 || v_wr_last_o !== 1'b0 || v_wr_mask_o !== 4'hF) begin
      errors++; $display("FAIL vf_beat0 got v=%0b b=%0d l=%0b m=%0h want 1/0/0/f",
                         v_wr_valid_o, v_wr_beat_o, v_wr_last_o, v_wr_mask_o); end
    checks++; if (v_wr_data_o !== {32'h103, 32'h102, 32'h101, 32'h100} || v_wr_idx_o !== 7'd7 || v_wr_wid_o !== 2'd1) begin
      errors++; $display("FAIL vf_data0 got d=%0h i=%0d w=%0d want 103..100/7/1", v_wr_data_o, v_wr_idx_o, v_wr_wid_o); end
    checks++; if (busy_o !== 1'b1 || outv_ready_o !== 1'b0) begin
      errors++; $display("FAIL vf_busy got busy=%0b rdy=%0b want 1/0", busy_o, outv_ready_o); end
    step();
    checks++; if (v_wr_valid_o !== 1'b1 || v_wr_beat_o !== 1'b1 || v_wr_last_o !== 1'b1 || v_wr_mask_o !== 4'hF) begin
      errors++; $display("FAIL vf_beat1 got v=%0b b=%0d l=%0b m=%0h want 1/1/1/f",
                         v_wr_valid_o, v_wr_beat_o, v_wr_last_o, v_wr_mask_o); end
    checks++; if (v_wr_data_o !== {32'h107, 32'h106, 32'h105, 32'h104} || outv_ready_o !== 1'b1) begin
      errors++; $display("FAIL vf_data1 got d=%0h rdy=%0b want 107..104/1", v_wr_data_o, outv_ready_o); end
    step();
    checks++; if (v_wr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL vf_done got v=%0b busy=%0b want 0/0", v_wr_valid_o, busy_o); end
  endtask

  task automatic test_vector_sparse();
    outv_valid_i = 1; outv_wvd_i = 1; outv_wb_wxd_rd_i = VEC_A; outv_wvd_mask_i = 8'hF0;
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b1 || v_wr_beat_o !== 1'b1 || v_wr_last_o !== 1'b1 || v_wr_mask_o !== 4'hF) begin
      errors++; $display("FAIL vs_beat got v=%0b b=%0d l=%0b m=%0h want 1/1/1/f",
                         v_wr_valid_o, v_wr_beat_o, v_wr_last_o, v_wr_mask_o); end
    checks++; if (v_wr_data_o !== {32'h107, 32'h106, 32'h105, 32'h104}) begin
      errors++; $display("FAIL vs_data got %0h want 107..104", v_wr_data_o); end
    step();
    checks++; if (v_wr_valid_o !== 1'b0) begin errors++; $display("FAIL vs_done got %0b want 0", v_wr_valid_o); end
    outv_valid_i = 1; outv_wvd_mask_i = 8'h00;
    checks++; if (outv_ready_o !== 1'b1) begin errors++; $display("FAIL vz_ready got %0b want 1", outv_ready_o); end
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL vz_nobeat got v=%0b busy=%0b want 0/0", v_wr_valid_o, busy_o); end
    outv_valid_i = 1; outv_wvd_i = 0; outv_wvd_mask_i = 8'hFF;
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL vwvd0 got v=%0b busy=%0b want 0/0", v_wr_valid_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    v_wr_ready_i = 1;
    outv_valid_i = 1; outv_wvd_i = 1; outv_wb_wxd_rd_i = VEC_A; outv_wvd_mask_i = 8'hFF; outv_reg_idxw_i = 7'd3;
    step();
    outv_valid_i = 0;
    step();
    checks++; if (v_wr_beat_o !== 1'b1 || v_wr_last_o !== 1'b1) begin
      errors++; $display("FAIL bb_lastA got b=%0d l=%0b want 1/1", v_wr_beat_o, v_wr_last_o); end
    outv_valid_i = 1; outv_wb_wxd_rd_i = VEC_B; outv_wvd_mask_i = 8'hFF; outv_reg_idxw_i = 7'd4;
    #1;
    checks++; if (outv_ready_o !== 1'b1) begin errors++; $display("FAIL bb_accept got %0b want 1", outv_ready_o); end
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b1 || v_wr_beat_o !== 1'b0 || v_wr_idx_o !== 7'd4 ||
                  v_wr_data_o !== {32'h203, 32'h202, 32'h201, 32'h200}) begin
      errors++; $display("FAIL bb_firstB got v=%0b b=%0d i=%0d d=%0h want 1/0/4/203..200",
                         v_wr_valid_o, v_wr_beat_o, v_wr_idx_o, v_wr_data_o); end
    v_wr_ready_i = 0;
    step(); step();
    checks++; if (v_wr_valid_o !== 1'b1 || v_wr_beat_o !== 1'b0 || outv_ready_o !== 1'b0 ||
                  v_wr_data_o !== {32'h203, 32'h202, 32'h201, 32'h200}) begin
      errors++; $display("FAIL bb_stall got v=%0b b=%0d rdy=%0b d=%0h want 1/0/0/203..200",
                         v_wr_valid_o, v_wr_beat_o, outv_ready_o, v_wr_data_o); end
    v_wr_ready_i = 1;
    step();
    checks++; if (v_wr_beat_o !== 1'b1 || v_wr_data_o !== {32'h207, 32'h206, 32'h205, 32'h204}) begin
      errors++; $display("FAIL bb_resume got b=%0d d=%0h want 1/207..204", v_wr_beat_o, v_wr_data_o); end
    step();
    checks++; if (v_wr_valid_o !== 1'b0) begin errors++; $display("FAIL bb_done got %0b want 0", v_wr_valid_o); end
  endtask

  task automatic test_reset_mid_send();
    v_wr_ready_i = 0;
    outv_valid_i = 1; outv_wvd_i = 1; outv_wb_wxd_rd_i = VEC_A; outv_wvd_mask_i = 8'hFF;
    step();
    outv_valid_i = 0;
    checks++; if (v_wr_valid_o !== 1'b1) begin errors++; $display("FAIL rm_pre got %0b want 1", v_wr_valid_o); end
    rst_n = 1'b0;
    step();
    checks++; if (v_wr_valid_o !== 1'b0 || outv_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rm_after got v=%0b rdy=%0b busy=%0b want 0/1/0", v_wr_valid_o, outv_ready_o, busy_o); end
    rst_n = 1'b1;
    v_wr_ready_i = 1;
    step();
    checks++; if (v_wr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_stay got %0b want 0", v_wr_valid_o); end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_scalar_stall();
    test_vector_full();
    test_vector_sparse();
    test_back_to_back();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
